centroid_tracker: RTL

- Upstream neighbour of the display mux. Accumulates the coordinates of thresholded (mask=1) pixels over one frame. At frame end, runs a shared iterative divider and produces the centroid (x,y).
- The centroid drives the crosshair generator, whose output becomes the mux's crosshair input. It also goes to the juggling logic.
- One instance per tracked colour channel.

---
 rtl/centroid_tracker.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/centroid_tracker.sv
// centroid_tracker: accumulates the coordinates of masked pixels over one
// frame and, at frame end, divides the x/y sums by the pixel count using two
// parallel restoring dividers (one quotient bit per cycle). The result feeds
// the crosshair generator and the juggling logic. One instance per channel.
//
// Optional build macro CENTROID_BBOX_EN adds a per-frame bounding box of the
// qualifying pixels, published in the same cycle as the centroid.
`timescale 1ns/1ps

module centroid_tracker #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int SUM_W    = 32,
  parameter int CNT_W    = 20
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  input  logic        mask_in,
  input  logic        frame_done_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        found_out,
  output logic        valid_out,
  output logic        busy_out
`ifdef CENTROID_BBOX_EN
  ,
  output logic [10:0] bbox_xmin_out,
  output logic [10:0] bbox_xmax_out,
  output logic [9:0]  bbox_ymin_out,
  output logic [9:0]  bbox_ymax_out
`endif
);

  localparam int STEP_W = $clog2(SUM_W);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0] state;

  // ---------------------------------------------------------------------------
  // Pixel qualification and accumulation
  // ---------------------------------------------------------------------------
  logic             pix_hit;
  logic [SUM_W-1:0] sum_x, sum_y;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] add_x, add_y;
  logic [SUM_W-1:0] final_x, final_y;
  logic [CNT_W-1:0] final_cnt;

  assign pix_hit = data_valid_in && mask_in &&
                   ({1'b0, hcount_in} < 12'(H_ACTIVE)) &&
                   ({1'b0, vcount_in} < 11'(V_ACTIVE));

  assign add_x = pix_hit ? SUM_W'(hcount_in) : '0;
  assign add_y = pix_hit ? SUM_W'(vcount_in) : '0;

  // A pixel arriving together with frame_done_in belongs to the closing frame,
  // so the snapshot is taken from these combined values, not the registers.
  assign final_x   = sum_x + add_x;
  assign final_y   = sum_y + add_y;
  assign final_cnt = count + CNT_W'(pix_hit);

  // FSM decision strobes shared by the centroid and bounding-box paths.
  logic start_div;
  logic start_zero;
  logic div_last;
  logic [STEP_W-1:0] step;

  assign start_div  = (state == S_IDLE) && frame_done_in && (final_cnt != '0);
  assign start_zero = (state == S_IDLE) && frame_done_in && (final_cnt == '0);
  assign div_last   = (state == S_DIVIDE) && (step == '0);

  // Accumulators: add qualifying pixels in every state, clear on frame close.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
    end else if (frame_done_in) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
    end else begin
      sum_x <= final_x;
      sum_y <= final_y;
      count <= final_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring divider step: shift in the next dividend bit, subtract the
  // divisor when it fits. Returns {new remainder, quotient bit}.
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W:0] div_step(input logic [CNT_W-1:0] rem,
                                               input logic             din,
                                               input logic [CNT_W-1:0] dvs);
    logic [CNT_W:0] trial;
    trial = {rem, din};
    if (trial >= {1'b0, dvs}) begin
      return {CNT_W'(trial - {1'b0, dvs}), 1'b1};
    end
    return {CNT_W'(trial), 1'b0};
  endfunction

  // Dividend shift registers double as quotient registers: each step shifts
  // the consumed dividend MSB out and the new quotient bit in at the LSB.
  logic [SUM_W-1:0] dvd_x, dvd_y;
  logic [CNT_W-1:0] rem_x, rem_y;
  logic [CNT_W-1:0] divisor;
  logic [CNT_W:0]   step_x, step_y;

  assign step_x = div_step(rem_x, dvd_x[SUM_W-1], divisor);
  assign step_y = div_step(rem_y, dvd_y[SUM_W-1], divisor);

  // Frame FSM, divider datapath and registered centroid outputs.
  // NOTE: the divider datapath is reset along with the control state so that
  // no register ever powers up unknown; there are no memory arrays here.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= S_IDLE;
      dvd_x     <= '0;
      dvd_y     <= '0;
      rem_x     <= '0;
      rem_y     <= '0;
      divisor   <= '0;
      step      <= '0;
      x_out     <= '0;
      y_out     <= '0;
      found_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_zero) begin
            // Empty frame: keep the last centroid, flag not found.
            found_out <= 1'b0;
            state     <= S_DONE;
          end else if (start_div) begin
            dvd_x   <= final_x;
            dvd_y   <= final_y;
            divisor <= final_cnt;
            rem_x   <= '0;
            rem_y   <= '0;
            step    <= STEP_W'(SUM_W - 1);
            state   <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          dvd_x <= {dvd_x[SUM_W-2:0], step_x[0]};
          dvd_y <= {dvd_y[SUM_W-2:0], step_y[0]};
          rem_x <= step_x[CNT_W:1];
          rem_y <= step_y[CNT_W:1];
          step  <= step - STEP_W'(1);
          if (div_last) begin
            // Final quotient bit joins the LSBs directly; floor division.
            x_out     <= {dvd_x[9:0], step_x[0]};
            y_out     <= {dvd_y[8:0], step_y[0]};
            found_out <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign valid_out = (state == S_DONE);
  assign busy_out  = (state == S_DIVIDE);

`ifdef CENTROID_BBOX_EN
  // ---------------------------------------------------------------------------
  // Bounding box: running min/max, snapshot at frame close, publish with the
  // centroid. Min trackers rest at the far corner, max trackers at zero.
  // ---------------------------------------------------------------------------
  localparam logic [10:0] X_MIN_INIT = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_MIN_INIT = 10'(V_ACTIVE - 1);

  logic [10:0] run_xmin, run_xmax, fin_xmin, fin_xmax, snap_xmin, snap_xmax;
  logic [9:0]  run_ymin, run_ymax, fin_ymin, fin_ymax, snap_ymin, snap_ymax;

  assign fin_xmin = (pix_hit && hcount_in < run_xmin) ? hcount_in : run_xmin;
  assign fin_xmax = (pix_hit && hcount_in > run_xmax) ? hcount_in : run_xmax;
  assign fin_ymin = (pix_hit && vcount_in < run_ymin) ? vcount_in : run_ymin;
  assign fin_ymax = (pix_hit && vcount_in > run_ymax) ? vcount_in : run_ymax;

  // Running extents: track in every state, return to rest on frame close.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      run_xmin <= X_MIN_INIT;
      run_xmax <= '0;
      run_ymin <= Y_MIN_INIT;
      run_ymax <= '0;
    end else if (frame_done_in) begin
      run_xmin <= X_MIN_INIT;
      run_xmax <= '0;
      run_ymin <= Y_MIN_INIT;
      run_ymax <= '0;
    end else begin
      run_xmin <= fin_xmin;
      run_xmax <= fin_xmax;
      run_ymin <= fin_ymin;
      run_ymax <= fin_ymax;
    end
  end

  // Snapshot on an accepted frame, publish when the division completes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      snap_xmin     <= '0;
      snap_xmax     <= '0;
      snap_ymin     <= '0;
      snap_ymax     <= '0;
      bbox_xmin_out <= '0;
      bbox_xmax_out <= '0;
      bbox_ymin_out <= '0;
      bbox_ymax_out <= '0;
    end else begin
      if (start_div) begin
        snap_xmin <= fin_xmin;
        snap_xmax <= fin_xmax;
        snap_ymin <= fin_ymin;
        snap_ymax <= fin_ymax;
      end
      if (start_zero) begin
        bbox_xmin_out <= '0;
        bbox_xmax_out <= '0;
        bbox_ymin_out <= '0;
        bbox_ymax_out <= '0;
      end else if (div_last) begin
        bbox_xmin_out <= snap_xmin;
        bbox_xmax_out <= snap_xmax;
        bbox_ymin_out <= snap_ymin;
        bbox_ymax_out <= snap_ymax;
      end
    end
  end
`endif

endmodule
